wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_mux2_1.sv | 13 +
 rtl/wb_arbiter.sv | 118 +++++++++++
 tb/tb_wb_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, state encodings and source codes for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int DATA_W  = 19;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/wb_arbiter_mux2_1.sv
// 2:1 data mux selecting the granted requester's result word (sel=1 picks b).
module wb_arbiter_mux2_1
    import wb_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter with round-robin or fixed priority, sticky
// ownership via lock, idle timeout on the owner, and a registered write port.
//
//  state | meaning
//  IDLE  | no owner; arbitrate between valid requesters
//  OWN_A | A holds the port after a locked beat; B is blocked
//  OWN_B | B holds the port after a locked beat; A is blocked
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_LOCK      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic               b_valid,
    output logic               a_ready,
    output logic               b_ready,
    input  logic [DATA_W-1:0]  a_data,
    input  logic [DATA_W-1:0]  b_data,
    input  logic [RADDR_W-1:0] a_addr,
    input  logic [RADDR_W-1:0] b_addr,
    input  logic               a_lock,
    input  logic               b_lock,
    input  logic               stall,
    output logic               wb_valid,
    output logic [DATA_W-1:0]  wb_data,
    output logic [RADDR_W-1:0] wb_addr,
    output logic               wb_src,
    output logic               lock_err
);

    state_t             state, state_nxt;
    logic               last_grant, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               grant_a, grant_b;
    logic               xfer, xfer_lock;
    logic [DATA_W-1:0]  mux_data;

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last_grant;
        lock_err  = 1'b0;

        case (state)
            IDLE: begin
                if (a_valid && !b_valid) begin
                    grant_a = 1'b1;
                end else if (!a_valid && b_valid) begin
                    grant_b = 1'b1;
                end else if (a_valid && b_valid) begin
                    if (PRIORITY_MODE == 1 || last_grant == SRC_B) grant_a = 1'b1;
                    else                                           grant_b = 1'b1;
                end
            end
            OWN_A:   grant_a = 1'b1;
            OWN_B:   grant_b = 1'b1;
            default: state_nxt = IDLE;
        endcase

        a_ready   = rst_n && grant_a && a_valid && !stall;
        b_ready   = rst_n && grant_b && b_valid && !stall;
        xfer      = a_ready || b_ready;
        xfer_lock = a_ready ? a_lock : b_lock;

        if (xfer) begin
            last_nxt  = b_ready;
            cnt_nxt   = '0;
            state_nxt = xfer_lock ? (a_ready ? OWN_A : OWN_B) : IDLE;
        end else if (!stall && (state == OWN_A || state == OWN_B)) begin
            // No transfer while owning and not stalled means the owner was idle.
            // lock_err flags the idle cycle that triggers the release.
            if (cnt == CNT_W'(MAX_LOCK - 1)) begin
                lock_err  = rst_n;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    wb_arbiter_mux2_1 u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (grant_b),
        .y   (mux_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SRC_B;
            cnt        <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_addr    <= '0;
            wb_src     <= SRC_A;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            cnt        <= cnt_nxt;
            if (!stall) begin
                wb_valid <= xfer;
                if (xfer) begin
                    wb_data <= mux_data;
                    wb_addr <= b_ready ? b_addr : a_addr;
                    wb_src  <= b_ready;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected beats are queued when a grant is
// predicted and popped when the registered write port should present them.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, a_lock, b_lock, stall;
    logic [18:0] a_data, b_data;
    logic [3:0]  a_addr, b_addr;

    logic        a_ready, b_ready, wb_valid, wb_src, lock_err;
    logic [18:0] wb_data;
    logic [3:0]  wb_addr;

    logic        p_a_ready, p_b_ready, p_wb_valid, p_wb_src, p_lock_err;
    logic [18:0] p_wb_data;
    logic [3:0]  p_wb_addr;

    int checks = 0;
    int errors = 0;

    // {src, addr, data}
    logic [23:0] sbq[$];
    logic [23:0] exp_beat;

    wb_arbiter #(.PRIORITY_MODE(0), .MAX_LOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_ready(a_ready), .b_ready(b_ready),
        .a_data(a_data), .b_data(b_data),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_lock(a_lock), .b_lock(b_lock),
        .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_src(wb_src), .lock_err(lock_err)
    );

    wb_arbiter #(.PRIORITY_MODE(1), .MAX_LOCK(8)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_ready(p_a_ready), .b_ready(p_b_ready),
        .a_data(a_data), .b_data(b_data),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_lock(a_lock), .b_lock(b_lock),
        .stall(stall),
        .wb_valid(p_wb_valid), .wb_data(p_wb_data), .wb_addr(p_wb_addr),
        .wb_src(p_wb_src), .lock_err(p_lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        stall = 1'b0; a_data = '0; b_data = '0; a_addr = '0; b_addr = '0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_lock = 1'b1; b_lock = 1'b1;
        stall = 1'b0; a_data = 19'h12345; b_data = 19'h54321; a_addr = 4'h3; b_addr = 4'hc;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_src, wb_addr, wb_data, lock_err} !== 26'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                               {wb_valid, wb_src, wb_addr, wb_data, lock_err});
        end
        checks++;
        if (dut.state !== 2'b00) begin
            errors++; $display("FAIL reset_state: got %b expected 00", dut.state);
        end
        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic exp_b;
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        a_data = 19'h7FFFF; a_addr = 4'h3;
        b_data = 19'h00001; b_addr = 4'h5;
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2) == 1;
            @(negedge clk);
            checks++;
            if ({a_ready, b_ready} !== {!exp_b, exp_b}) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                                   {a_ready, b_ready}, {!exp_b, exp_b});
            end
            sbq.push_back(exp_b ? {1'b1, 4'h5, 19'h00001} : {1'b0, 4'h3, 19'h7FFFF});
            @(posedge clk); #1;
            checks++;
            exp_beat = sbq.pop_front();
            if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
                errors++; $display("FAIL rr_wb[%0d]: got %h expected %h", i,
                                   {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b0, 1'b1, 4'h5, 19'h00001}) begin
            errors++; $display("FAIL rr_idle_hold: got %h expected %h",
                               {wb_valid, wb_src, wb_addr, wb_data}, {1'b0, 1'b1, 4'h5, 19'h00001});
        end
    endtask

    task automatic test_priority;
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        a_data = 19'h11111; a_addr = 4'h3;
        b_data = 19'h22222; b_addr = 4'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({p_a_ready, p_b_ready} !== 2'b10) begin
                errors++; $display("FAIL prio_grant[%0d]: got %b expected 10", i,
                                   {p_a_ready, p_b_ready});
            end
            @(posedge clk); #1;
            checks++;
            if ({p_wb_valid, p_wb_src, p_wb_addr, p_wb_data} !== {1'b1, 1'b0, 4'h3, 19'h11111}) begin
                errors++; $display("FAIL prio_wb[%0d]: got %h expected %h", i,
                                   {p_wb_valid, p_wb_src, p_wb_addr, p_wb_data},
                                   {1'b1, 1'b0, 4'h3, 19'h11111});
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_lock;
        logic [2:0] locks;
        locks = 3'b011;
        do_reset();
        b_valid = 1'b1; b_data = 19'h0BEEF; b_addr = 4'hb; b_lock = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                a_lock = locks[i];
                a_data = 19'h40000 + 19'(i);
                a_addr = 4'(i + 1);
            end else begin
                a_valid = 1'b0;
                a_lock = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({a_ready, b_ready} !== ((i < 3) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL lock_grant[%0d]: got %b expected %b", i,
                                   {a_ready, b_ready}, (i < 3) ? 2'b10 : 2'b01);
            end
            if (i < 3) sbq.push_back({1'b0, 4'(i + 1), 19'h40000 + 19'(i)});
            else       sbq.push_back({1'b1, 4'hb, 19'h0BEEF});
            @(posedge clk); #1;
            checks++;
            exp_beat = sbq.pop_front();
            if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
                errors++; $display("FAIL lock_wb[%0d]: got %h expected %h", i,
                                   {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
            end
        end
        checks++;
        if (dut.state !== 2'b00) begin
            errors++; $display("FAIL lock_state_idle: got %b expected 00", dut.state);
        end
        b_valid = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset();
        a_valid = 1'b1; a_lock = 1'b1; a_data = 19'h0ABCD; a_addr = 4'h7;
        b_valid = 1'b1; b_lock = 1'b0; b_data = 19'h54321; b_addr = 4'h9;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL to_first: got %b expected 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_lock = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({b_ready, lock_err} !== {1'b0, (k == 8)}) begin
                errors++; $display("FAIL to_idle[%0d]: got ready,err=%b expected %b", k,
                                   {b_ready, lock_err}, {1'b0, (k == 8)});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({b_ready, lock_err} !== 2'b10) begin
            errors++; $display("FAIL to_release: got ready,err=%b expected 10", {b_ready, lock_err});
        end
        sbq.push_back({1'b1, 4'h9, 19'h54321});
        @(posedge clk); #1;
        checks++;
        exp_beat = sbq.pop_front();
        if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
            errors++; $display("FAIL to_wb: got %h expected %h",
                               {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
        end
        b_valid = 1'b0;
    endtask

    task automatic test_stall;
        logic [6:0]  st;
        logic        exp_b;
        logic [23:0] held;
        int          n;
        st = 7'b0011100;
        n = 0;
        held = '0;
        do_reset();
        a_valid = 1'b1; a_data = 19'h2AAAA; a_addr = 4'h1;
        b_valid = 1'b1; b_data = 19'h15555; b_addr = 4'h2;
        for (int i = 0; i < 7; i++) begin
            stall = st[i];
            exp_b = (n % 2) == 1;
            @(negedge clk);
            checks++;
            if (st[i]) begin
                if ({a_ready, b_ready} !== 2'b00) begin
                    errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", i, {a_ready, b_ready});
                end
            end else begin
                if ({a_ready, b_ready} !== {!exp_b, exp_b}) begin
                    errors++; $display("FAIL stall_grant[%0d]: got %b expected %b", i,
                                       {a_ready, b_ready}, {!exp_b, exp_b});
                end
                sbq.push_back(exp_b ? {1'b1, 4'h2, 19'h15555} : {1'b0, 4'h1, 19'h2AAAA});
                n++;
            end
            @(posedge clk); #1;
            checks++;
            if (sbq.size() != 0) begin
                exp_beat = sbq.pop_front();
                held = exp_beat;
                if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
                    errors++; $display("FAIL stall_wb[%0d]: got %h expected %h", i,
                                       {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
                end
            end else if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, held}) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i,
                                   {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, held});
            end
        end
        stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_reset_mid_lock;
        do_reset();
        a_valid = 1'b1; a_lock = 1'b1; a_data = 19'h33333; a_addr = 4'h6;
        b_valid = 1'b1; b_lock = 1'b0; b_data = 19'h44444; b_addr = 4'h8;
        @(negedge clk);
        sbq.push_back({1'b0, 4'h6, 19'h33333});
        @(posedge clk); #1;
        checks++;
        exp_beat = sbq.pop_front();
        if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
            errors++; $display("FAIL rml_first: got %h expected %h",
                               {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL rml_ready: got %b expected 00", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_src, wb_addr, wb_data, lock_err} !== 26'h0 || dut.state !== 2'b00) begin
            errors++; $display("FAIL rml_outputs: got %h state %b expected 0 state 00",
                               {wb_valid, wb_src, wb_addr, wb_data, lock_err}, dut.state);
        end
        rst_n = 1'b1; a_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL rml_tie: got %b expected 10", {a_ready, b_ready});
        end
        sbq.push_back({1'b0, 4'h6, 19'h33333});
        @(posedge clk); #1;
        checks++;
        exp_beat = sbq.pop_front();
        if ({wb_valid, wb_src, wb_addr, wb_data} !== {1'b1, exp_beat}) begin
            errors++; $display("FAIL rml_wb: got %h expected %h",
                               {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, exp_beat});
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        stall = 1'b0; a_data = '0; b_data = '0; a_addr = '0; b_addr = '0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_priority();
        test_lock();
        test_timeout();
        test_stall();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
